// File: rtl/jtag_types_pkg.sv
// Shared JTAG types: instruction decode enum and default opcodes.
// Imported by the IR, its decoder and the DR mux checker.
package jtag_types_pkg;

    typedef enum logic [1:0] {
        BYPASS         = 2'd0,
        IDCODE         = 2'd1,
        SAMPLE_PRELOAD = 2'd2,
        EXTEST         = 2'd3
    } instruction_decode_t;

    localparam int          DEF_IR_WIDTH    = 4;
    localparam logic [3:0]  DEF_RESET_INSTR = 4'h1;
    localparam logic [3:0]  DEF_OPC_EXTEST  = 4'h0;
    localparam logic [3:0]  DEF_OPC_IDCODE  = 4'h1;
    localparam logic [3:0]  DEF_OPC_SAMPLE  = 4'h2;

    // Fixed capture LSBs let the debugger detect a broken IR scan chain
    localparam logic [1:0]  IR_CAPTURE_LSBS = 2'b01;

endpackage

// File: rtl/jtag_ir_decode.sv
// Combinational opcode to instruction mapping with a legal flag.
// Unknown opcodes fall back to BYPASS.
module jtag_ir_decode
    import jtag_types_pkg::*;
#(
    parameter int                  IR_WIDTH   = DEF_IR_WIDTH,
    parameter logic [IR_WIDTH-1:0] OPC_EXTEST = IR_WIDTH'(DEF_OPC_EXTEST),
    parameter logic [IR_WIDTH-1:0] OPC_IDCODE = IR_WIDTH'(DEF_OPC_IDCODE),
    parameter logic [IR_WIDTH-1:0] OPC_SAMPLE = IR_WIDTH'(DEF_OPC_SAMPLE),
    parameter logic [IR_WIDTH-1:0] OPC_BYPASS = '1
) (
    input  logic [IR_WIDTH-1:0] opcode,
    output instruction_decode_t decode,
    output logic                legal
);

    always_comb begin
        decode = BYPASS;
        legal  = 1'b1;
        unique case (1'b1)
            (opcode == OPC_EXTEST): decode = EXTEST;
            (opcode == OPC_IDCODE): decode = IDCODE;
            (opcode == OPC_SAMPLE): decode = SAMPLE_PRELOAD;
            (opcode == OPC_BYPASS): decode = BYPASS;
            default:                legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/jtag_ir_param.sv
// Parametrised JTAG instruction register: capture/shift/update path,
// shift-length counting, update pulse and sticky illegal-opcode flag.
module jtag_ir_param
    import jtag_types_pkg::*;
#(
    parameter int                  IR_WIDTH      = DEF_IR_WIDTH,
    parameter logic [IR_WIDTH-1:0] RESET_INSTR   = IR_WIDTH'(DEF_RESET_INSTR),
    parameter logic [IR_WIDTH-1:0] OPC_EXTEST    = IR_WIDTH'(DEF_OPC_EXTEST),
    parameter logic [IR_WIDTH-1:0] OPC_IDCODE    = IR_WIDTH'(DEF_OPC_IDCODE),
    parameter logic [IR_WIDTH-1:0] OPC_SAMPLE    = IR_WIDTH'(DEF_OPC_SAMPLE),
    parameter logic [IR_WIDTH-1:0] OPC_BYPASS    = '1,
    parameter bit                  STRICT_LENGTH = 1'b0,
    localparam int                 CW            = $clog2(IR_WIDTH + 1)
) (
    input  logic                TCK,
    input  logic                nTRST,
    input  logic                TDI,
    input  logic                ir_capture,
    input  logic                ir_shift,
    input  logic                ir_update,
    input  logic                test_reset,
    input  logic                tlr_reset,
    input  logic [IR_WIDTH-3:0] capture_status,
    output logic                TDO,
    output logic [IR_WIDTH-1:0] ir_value,
    output instruction_decode_t parallel_out,
    output logic                ir_updated,
    output logic                illegal_instr,
    output logic [CW-1:0]       shift_count
);

    if (IR_WIDTH < 2) begin : g_bad_width
        $error("jtag_ir_param: IR_WIDTH must be at least 2");
    end

    if (OPC_EXTEST == OPC_IDCODE || OPC_EXTEST == OPC_SAMPLE ||
        OPC_EXTEST == OPC_BYPASS || OPC_IDCODE == OPC_SAMPLE ||
        OPC_IDCODE == OPC_BYPASS || OPC_SAMPLE == OPC_BYPASS)
    begin : g_dup_opcode
        $error("jtag_ir_param: opcode parameters must be distinct");
    end

    localparam logic [IR_WIDTH-1:0] RESET_SHIFT = IR_WIDTH'(IR_CAPTURE_LSBS);
    localparam logic [CW-1:0]       FULL_COUNT  = CW'(IR_WIDTH);

    logic [IR_WIDTH-1:0] shift_reg;
    logic [IR_WIDTH-1:0] update_reg;
    logic [CW-1:0]       count;
    logic                sync_reset;
    logic                length_ok;
    logic                shift_legal;
    instruction_decode_t unused_shift_decode;

    assign sync_reset = test_reset | tlr_reset;
    assign length_ok  = !STRICT_LENGTH || (count == FULL_COUNT);

    // Shift register and bit counter
    always_ff @(posedge TCK or negedge nTRST) begin
        if (!nTRST) begin
            shift_reg <= RESET_SHIFT;
            count     <= '0;
        end else if (sync_reset) begin
            shift_reg <= RESET_SHIFT;
            count     <= '0;
        end else if (ir_capture) begin
            shift_reg <= {capture_status, IR_CAPTURE_LSBS};
            count     <= '0;
        end else if (ir_shift) begin
            shift_reg <= {TDI, shift_reg[IR_WIDTH-1:1]};
            if (count != FULL_COUNT) begin
                count <= count + 1'b1;
            end
        end
    end

    // Update register, load pulse and sticky illegal flag
    always_ff @(posedge TCK or negedge nTRST) begin
        if (!nTRST) begin
            update_reg    <= RESET_INSTR;
            ir_updated    <= 1'b0;
            illegal_instr <= 1'b0;
        end else if (sync_reset) begin
            update_reg    <= RESET_INSTR;
            ir_updated    <= 1'b0;
            illegal_instr <= 1'b0;
        end else begin
            ir_updated <= 1'b0;
            if (!ir_capture && !ir_shift && ir_update) begin
                if (length_ok) begin
                    update_reg <= shift_reg;
                    ir_updated <= 1'b1;
                    if (!shift_legal) begin
                        illegal_instr <= 1'b1;
                    end
                end else begin
                    illegal_instr <= 1'b1;
                end
            end
        end
    end

    // Legality of the opcode about to be loaded
    jtag_ir_decode #(
        .IR_WIDTH   (IR_WIDTH),
        .OPC_EXTEST (OPC_EXTEST),
        .OPC_IDCODE (OPC_IDCODE),
        .OPC_SAMPLE (OPC_SAMPLE),
        .OPC_BYPASS (OPC_BYPASS)
    ) u_shift_decode (
        .opcode (shift_reg),
        .decode (unused_shift_decode),
        .legal  (shift_legal)
    );

    logic active_legal;

    jtag_ir_decode #(
        .IR_WIDTH   (IR_WIDTH),
        .OPC_EXTEST (OPC_EXTEST),
        .OPC_IDCODE (OPC_IDCODE),
        .OPC_SAMPLE (OPC_SAMPLE),
        .OPC_BYPASS (OPC_BYPASS)
    ) u_active_decode (
        .opcode (update_reg),
        .decode (parallel_out),
        .legal  (active_legal)
    );

    logic unused_active_legal;
    assign unused_active_legal = active_legal;

    assign TDO         = shift_reg[0];
    assign ir_value    = update_reg;
    assign shift_count = count;

endmodule

// File: tb/tb_jtag_ir_param.sv
// Scoreboard bench for jtag_ir_param: a lenient and a strict-length
// instance share stimulus; expectations are queued and checked after edges.
module tb_jtag_ir_param;
    import jtag_types_pkg::*;

    logic       TCK = 1'b0;
    logic       nTRST = 1'b0;
    logic       TDI = 1'b0;
    logic       ir_capture = 1'b0;
    logic       ir_shift = 1'b0;
    logic       ir_update = 1'b0;
    logic       test_reset = 1'b0;
    logic       tlr_reset = 1'b0;
    logic [1:0] capture_status = 2'b00;

    logic                TDO, TDO_s;
    logic [3:0]          ir_value, ir_value_s;
    instruction_decode_t parallel_out, parallel_out_s;
    logic                ir_updated, ir_updated_s;
    logic                illegal_instr, illegal_instr_s;
    logic [2:0]          shift_count, shift_count_s;

    jtag_ir_param dut (
        .TCK            (TCK),
        .nTRST          (nTRST),
        .TDI            (TDI),
        .ir_capture     (ir_capture),
        .ir_shift       (ir_shift),
        .ir_update      (ir_update),
        .test_reset     (test_reset),
        .tlr_reset      (tlr_reset),
        .capture_status (capture_status),
        .TDO            (TDO),
        .ir_value       (ir_value),
        .parallel_out   (parallel_out),
        .ir_updated     (ir_updated),
        .illegal_instr  (illegal_instr),
        .shift_count    (shift_count)
    );

    jtag_ir_param #(.STRICT_LENGTH(1'b1)) dut_s (
        .TCK            (TCK),
        .nTRST          (nTRST),
        .TDI            (TDI),
        .ir_capture     (ir_capture),
        .ir_shift       (ir_shift),
        .ir_update      (ir_update),
        .test_reset     (test_reset),
        .tlr_reset      (tlr_reset),
        .capture_status (capture_status),
        .TDO            (TDO_s),
        .ir_value       (ir_value_s),
        .parallel_out   (parallel_out_s),
        .ir_updated     (ir_updated_s),
        .illegal_instr  (illegal_instr_s),
        .shift_count    (shift_count_s)
    );

    always #5 TCK = ~TCK;

    localparam int S_IRV = 0, S_PO = 1, S_TDO = 2, S_ILL = 3, S_UPD = 4, S_CNT = 5;
    localparam int STRICT = 8;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_IRV:          return 32'(ir_value);
            S_PO:           return 32'(parallel_out);
            S_TDO:          return 32'(TDO);
            S_ILL:          return 32'(illegal_instr);
            S_UPD:          return 32'(ir_updated);
            S_CNT:          return 32'(shift_count);
            STRICT + S_IRV: return 32'(ir_value_s);
            STRICT + S_PO:  return 32'(parallel_out_s);
            STRICT + S_TDO: return 32'(TDO_s);
            STRICT + S_ILL: return 32'(illegal_instr_s);
            STRICT + S_UPD: return 32'(ir_updated_s);
            STRICT + S_CNT: return 32'(shift_count_s);
            default:        return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic want(input string tag, input int sel, input logic [31:0] v);
        sb.push_back('{tag, sel, v});
    endtask

    // Same expectation for both instances
    task automatic want2(input string tag, input int sel, input logic [31:0] v);
        want(tag, sel, v);
        want({tag, "_s"}, STRICT + sel, v);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic tick();
        @(posedge TCK);
        #1;
        drain();
    endtask

    task automatic capture();
        ir_capture = 1'b1;
        tick();
        ir_capture = 1'b0;
    endtask

    task automatic shift_in(input logic [7:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            TDI = bits[i];
            ir_shift = 1'b1;
            tick();
        end
        ir_shift = 1'b0;
        TDI = 1'b0;
    endtask

    task automatic update();
        ir_update = 1'b1;
        tick();
        ir_update = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] tdo_seq;
        tdo_seq = 4'b0100;

        // Asynchronous reset
        #12;
        want2("rst_irv", S_IRV, 32'h1);
        want2("rst_po", S_PO, 32'(IDCODE));
        want2("rst_tdo", S_TDO, 32'h1);
        want2("rst_ill", S_ILL, 32'h0);
        want2("rst_cnt", S_CNT, 32'h0);
        want2("rst_upd", S_UPD, 32'h0);
        drain();
        @(negedge TCK);
        nTRST = 1'b1;
        want2("post_rst_irv", S_IRV, 32'h1);
        tick();

        // Capture status 2'b10 and shift the pattern out
        capture_status = 2'b10;
        want2("cap_tdo", S_TDO, 32'h1);
        want2("cap_cnt", S_CNT, 32'h0);
        capture();
        for (int i = 0; i < 4; i++) begin
            TDI = 1'b0;
            ir_shift = 1'b1;
            want2($sformatf("sh_tdo%0d", i), S_TDO, 32'(tdo_seq[i]));
            want2($sformatf("sh_cnt%0d", i), S_CNT, 32'(i + 1));
            tick();
        end
        ir_shift = 1'b0;
        want2("idle_irv", S_IRV, 32'h1);
        want2("idle_cnt", S_CNT, 32'h4);
        tick();

        // Normal update to BYPASS
        capture();
        shift_in(8'h0F, 4);
        want2("byp_upd", S_UPD, 32'h1);
        want2("byp_irv", S_IRV, 32'hF);
        want2("byp_po", S_PO, 32'(BYPASS));
        want2("byp_ill", S_ILL, 32'h0);
        update();
        want2("byp_upd_end", S_UPD, 32'h0);
        tick();

        // Unknown opcode, then a valid one: flag stays set
        capture();
        shift_in(8'h05, 4);
        want2("unk_irv", S_IRV, 32'h5);
        want2("unk_po", S_PO, 32'(BYPASS));
        want2("unk_ill", S_ILL, 32'h1);
        update();
        capture();
        shift_in(8'h02, 4);
        want2("smp_irv", S_IRV, 32'h2);
        want2("smp_po", S_PO, 32'(SAMPLE_PRELOAD));
        want2("smp_ill", S_ILL, 32'h1);
        update();
        #2;
        nTRST = 1'b0;
        want2("clr_ill", S_ILL, 32'h0);
        want2("clr_irv", S_IRV, 32'h1);
        #1;
        drain();
        @(negedge TCK);
        nTRST = 1'b1;

        // Short shift: strict instance rejects the update
        capture();
        shift_in(8'h00, 3);
        want("short_upd", S_UPD, 32'h1);
        want("short_ill", S_ILL, 32'h0);
        want("short_irv_s", STRICT + S_IRV, 32'h1);
        want("short_upd_s", STRICT + S_UPD, 32'h0);
        want("short_ill_s", STRICT + S_ILL, 32'h1);
        update();

        // Over-long shift: count saturates and strict update is accepted
        capture();
        shift_in(8'h03, 6);
        want2("long_cnt", S_CNT, 32'h4);
        drain();
        want2("long_irv", S_IRV, 32'h0);
        want2("long_po", S_PO, 32'(EXTEST));
        want2("long_upd", S_UPD, 32'h1);
        want("long_ill", S_ILL, 32'h0);
        want("long_ill_s", STRICT + S_ILL, 32'h1);
        update();

        // Capture wins over a simultaneous shift
        ir_shift = 1'b1;
        TDI = 1'b0;
        want2("prio_cnt", S_CNT, 32'h0);
        want2("prio_tdo", S_TDO, 32'h1);
        capture();
        ir_shift = 1'b0;

        // Synchronous reset mid-shift
        shift_in(8'h03, 2);
        want2("mid_cnt", S_CNT, 32'h2);
        drain();
        tlr_reset = 1'b1;
        ir_shift = 1'b1;
        want2("tlr_irv", S_IRV, 32'h1);
        want2("tlr_cnt", S_CNT, 32'h0);
        want2("tlr_tdo", S_TDO, 32'h1);
        want2("tlr_ill", S_ILL, 32'h0);
        tick();
        tlr_reset = 1'b0;
        ir_shift = 1'b0;

        // test_reset overrides a pending update
        capture();
        shift_in(8'h0F, 4);
        test_reset = 1'b1;
        ir_update = 1'b1;
        want2("trst_irv", S_IRV, 32'h1);
        want2("trst_upd", S_UPD, 32'h0);
        tick();
        test_reset = 1'b0;
        ir_update = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/jtag_ir_param.md
Name: jtag_ir_param

Overview:
- Parametrised JTAG instruction register for the JTAG debug block.
- Receives capture/shift/update strobes from the TAP controller, shifts the instruction in from TDI, and shifts the capture pattern out on TDO.
- Holds the active instruction in an update register and decodes it for the data-register mux.
- Beyond the previous IR:
  - IR length and opcodes are configurable.
  - Design-specific status bits are captured.
  - The number of bits shifted is counted, with optional strict-length rejection.
  - An update-done pulse and a sticky illegal-opcode flag are provided.

Parameters:
- IR_WIDTH, 4: instruction register length in bits, minimum 2.
- RESET_INSTR, 4'h1: opcode loaded on any reset (IDCODE).
- OPC_EXTEST, 4'h0: EXTEST opcode.
- OPC_IDCODE, 4'h1: IDCODE opcode.
- OPC_SAMPLE, 4'h2: SAMPLE/PRELOAD opcode.
- OPC_BYPASS, all ones: BYPASS opcode.
- STRICT_LENGTH, 0: if 1, an update is ignored unless exactly IR_WIDTH shift cycles occurred since the last capture.

Ports:
- TCK, in, 1: JTAG test clock. The only clock; all state updates on the rising edge.
- nTRST, in, 1: asynchronous active-low reset.
- TDI, in, 1: serial data in.
- ir_capture, in, 1: TAP Capture-IR.
- ir_shift, in, 1: TAP Shift-IR.
- ir_update, in, 1: TAP Update-IR.
- test_reset, in, 1: synchronous reset request from the TAP.
- tlr_reset, in, 1: synchronous Test-Logic-Reset state indication.
- capture_status, in, IR_WIDTH-2: design status captured into bits [IR_WIDTH-1:2].
- TDO, out, 1: serial out, equal to shift_reg[0]; retimed to falling edge by the top-level output stage.
- ir_value, out, IR_WIDTH: raw contents of the update register.
- parallel_out, out, instruction_decode_t: decoded active instruction.
- ir_updated, out, 1: one-cycle pulse when the update register loads.
- illegal_instr, out, 1: sticky flag, set when an unrecognised opcode is loaded.
- shift_count, out, $clog2(IR_WIDTH+1): shift cycles since capture, saturating at IR_WIDTH.

Behaviour:
- Reset state: on nTRST low, or on a rising edge with test_reset or tlr_reset high:
  - shift_reg = {capture_status=0, 2'b01} pattern zero-filled, i.e. {(IR_WIDTH-2){0}, 2'b01};
  - update_reg = RESET_INSTR;
  - shift_count = 0, ir_updated = 0, illegal_instr = 0;
  - TDO = 1 (shift_reg[0]); parallel_out = decode of RESET_INSTR.
- Priority per edge: reset > capture > shift > update. The TAP asserts strobes one-hot; overlap must still resolve by this priority.
- Capture:
  - shift_reg <= {capture_status, 2'b01}; shift_count <= 0.
  - The 2'b01 LSBs are mandatory for IR integrity checks.
- Shift:
  - shift_reg <= {TDI, shift_reg[IR_WIDTH-1:1]}, LSB-first out.
  - shift_count increments and saturates at IR_WIDTH; beyond IR_WIDTH shifts the register keeps shifting and the count holds.
- Update:
  - If STRICT_LENGTH=0, or shift_count==IR_WIDTH: update_reg <= shift_reg and ir_updated pulses high for one cycle.
  - Otherwise update_reg holds, no pulse is issued, and illegal_instr is set.
- Decode: combinational from update_reg, so the new decode is visible the cycle after the update edge.
  - OPC_EXTEST→EXTEST, OPC_IDCODE→IDCODE, OPC_SAMPLE→SAMPLE_PRELOAD, OPC_BYPASS→BYPASS.
  - Any other opcode decodes to BYPASS (1149.1 rule) and sets illegal_instr on the loading edge.
- illegal_instr clears only on reset.
- Idle: with no strobe active, all registers hold; TDO continues to reflect shift_reg[0].
- Reset mid-shift: partial shift contents are discarded and the instruction returns to RESET_INSTR.
- Elaboration: fail if IR_WIDTH<2, or if any two opcode parameters are equal.

Decomposition:
- jtag_types_pkg: instruction_decode_t enum {BYPASS, IDCODE, SAMPLE_PRELOAD, EXTEST} and default opcode constants.
- Interface: the IR interface gains capture_status, ir_value, ir_updated, illegal_instr and shift_count, and is parametrised by IR_WIDTH.
- Sub-module: jtag_ir_decode, a combinational opcode→enum mapping with a legal flag, reused by the DR mux checker.

Test Plan:
- Reset: nTRST low, then high → ir_value=4'h1, parallel_out=IDCODE, TDO=1, illegal_instr=0.
- Capture and shift-out: capture_status=2'b10, capture, then 4 shifts with TDI=0 → TDO sequence 1,0,0,1 (LSB first).
- Normal update: capture, shift in 4'hF LSB-first, update → ir_updated pulses once the following cycle, parallel_out=BYPASS, illegal_instr=0.
- Unknown opcode: shift in 4'h5, update → parallel_out=BYPASS, ir_value=4'h5, illegal_instr=1, and it stays 1 after a later valid update of 4'h2.
- Strict length: STRICT_LENGTH=1, capture, 3 shifts, update → ir_value unchanged, no ir_updated, illegal_instr=1. With 6 shifts, shift_count=4 and the update is accepted.
- Synchronous reset: assert tlr_reset mid-shift after 2 bits → next edge ir_value=4'h1, shift_count=0, TDO=1.
